// File: rtl/hilo_muldiv.sv
// HI/LO register pair with a single-cycle multiplier and a 32-iteration radix-2 restoring divider.
// Divides stall the pipeline through div_busy; the result lands in HI/LO at the DONE edge.
module hilo_muldiv (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  alucontrolE,
   input  logic [31:0] srcaE,
   input  logic [31:0] srcbE,
   input  logic        validE,
   input  logic        cancelE,
   output logic        div_busy,
   output logic        div_done,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam logic [4:0] AluMult  = 5'd12;
   localparam logic [4:0] AluMultu = 5'd13;
   localparam logic [4:0] AluDiv   = 5'd14;
   localparam logic [4:0] AluDivu  = 5'd15;

   typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] a_raw_q, a_raw_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic        dbz_q, dbz_d;

   logic        is_mul, is_div, signed_div, signed_mul;
   logic        accept, start_mul, start_div;
   logic [63:0] mul_a, mul_b, prod;
   logic [31:0] abs_a, abs_b;
   logic [32:0] shifted, trial;
   logic [31:0] quo_fix, rem_fix;

   always_comb begin
      is_mul     = (alucontrolE == AluMult) || (alucontrolE == AluMultu);
      is_div     = (alucontrolE == AluDiv)  || (alucontrolE == AluDivu);
      signed_mul = (alucontrolE == AluMult);
      signed_div = (alucontrolE == AluDiv);
      accept     = (state_q == StIdle) && validE && !cancelE;
      start_mul  = accept && is_mul;
      start_div  = accept && is_div;

      // One 64x64 multiplier serves both flavours; low 64 bits of the extended product are exact.
      mul_a = {{32{signed_mul & srcaE[31]}}, srcaE};
      mul_b = {{32{signed_mul & srcbE[31]}}, srcbE};
      prod  = mul_a * mul_b;

      abs_a = (signed_div && srcaE[31]) ? -srcaE : srcaE;
      abs_b = (signed_div && srcbE[31]) ? -srcbE : srcbE;

      // Remainder stays below the divisor, so the 33-bit trial difference never wraps.
      shifted = {rem_q, dvd_q[31]};
      trial   = shifted - {1'b0, dvs_q};

      quo_fix = neg_quo_q ? -dvd_q : dvd_q;
      rem_fix = neg_rem_q ? -rem_q : rem_q;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      a_raw_d   = a_raw_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;

      unique case (state_q)
         StIdle: begin
            if (start_mul) begin
               hi_d = prod[63:32];
               lo_d = prod[31:0];
            end else if (start_div) begin
               dvd_d     = abs_a;
               dvs_d     = abs_b;
               a_raw_d   = srcaE;
               neg_quo_d = signed_div & (srcaE[31] ^ srcbE[31]);
               neg_rem_d = signed_div & srcaE[31];
               dbz_d     = (srcbE == 32'd0);
               rem_d     = 32'd0;
               cnt_d     = 6'd0;
               state_d   = StDiv;
            end
         end
         StDiv: begin
            if (cancelE) begin
               state_d = StIdle;
            end else begin
               rem_d = trial[32] ? shifted[31:0] : trial[31:0];
               dvd_d = {dvd_q[30:0], ~trial[32]};
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
            if (!cancelE) begin
               hi_d = dbz_q ? a_raw_q : rem_fix;
               lo_d = dbz_q ? 32'hFFFF_FFFF : quo_fix;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= 6'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         rem_q     <= 32'd0;
         dvd_q     <= 32'd0;
         dvs_q     <= 32'd0;
         a_raw_q   <= 32'd0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         rem_q     <= rem_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         a_raw_q   <= a_raw_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
      end
   end

   assign div_busy = start_div || ((state_q == StDiv) && !cancelE);
   assign div_done = (state_q == StDone);
   assign hi_o     = hi_q;
   assign lo_o     = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: multiply, divide latency/results, cancel, reset and DONE hold.
module tb_hilo_muldiv;

   localparam logic [4:0] AluNop   = 5'd0;
   localparam logic [4:0] AluMult  = 5'd12;
   localparam logic [4:0] AluMultu = 5'd13;
   localparam logic [4:0] AluDiv   = 5'd14;
   localparam logic [4:0] AluDivu  = 5'd15;
   localparam logic [4:0] AluMfhi  = 5'd16;

   logic        clk;
   logic        rst;
   logic [4:0]  alucontrolE;
   logic [31:0] srcaE;
   logic [31:0] srcbE;
   logic        validE;
   logic        cancelE;
   logic        div_busy;
   logic        div_done;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int vectors = 0;
   int miscompares = 0;

   hilo_muldiv dut (
      .clk         (clk),
      .rst         (rst),
      .alucontrolE (alucontrolE),
      .srcaE       (srcaE),
      .srcbE       (srcbE),
      .validE      (validE),
      .cancelE     (cancelE),
      .div_busy    (div_busy),
      .div_done    (div_done),
      .hi_o        (hi_o),
      .lo_o        (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alucontrolE = AluNop;
      srcaE       = 32'd0;
      srcbE       = 32'd0;
      validE      = 1'b0;
      cancelE     = 1'b0;
   endtask

   // Runs one divide held in E through DONE; cycle 0 is the accept cycle, cycle 34 is sampled.
   task automatic do_div(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         output int busy_n, output int last_busy, output int done_n,
                         output int done_at, output logic [31:0] hi_s, output logic [31:0] lo_s);
      busy_n = 0; last_busy = -1; done_n = 0; done_at = -1;
      hi_s = 32'd0; lo_s = 32'd0;
      for (int c = 0; c <= 34; c++) begin
         if (c < 34) begin
            alucontrolE = ctrl; srcaE = a; srcbE = b; validE = 1'b1;
         end else begin
            idle_inputs();
         end
         #1;
         if (div_busy) begin busy_n++; last_busy = c; end
         if (div_done) begin done_n++; done_at = c; end
         if (c == 34) begin hi_s = hi_o; lo_s = lo_o; end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      step();
      step();
      rst = 1'b0;
      #1;
      vectors++;
      if (hi_o !== 32'd0) begin
         miscompares++; $display("FAIL reset_hi: got %h expected %h", hi_o, 32'd0);
      end
      vectors++;
      if (lo_o !== 32'd0) begin
         miscompares++; $display("FAIL reset_lo: got %h expected %h", lo_o, 32'd0);
      end
      vectors++;
      if (div_busy !== 1'b0) begin
         miscompares++; $display("FAIL reset_busy: got %b expected 0", div_busy);
      end
      vectors++;
      if (div_done !== 1'b0) begin
         miscompares++; $display("FAIL reset_done: got %b expected 0", div_done);
      end
   endtask

   task automatic test_mul();
      logic [4:0]  ctrl [2];
      logic [31:0] exp_hi [2];
      ctrl[0] = AluMult;  exp_hi[0] = 32'hFFFF_FFFF;
      ctrl[1] = AluMultu; exp_hi[1] = 32'h0000_0002;
      for (int i = 0; i < 2; i++) begin
         alucontrolE = ctrl[i]; srcaE = 32'hFFFF_FFFE; srcbE = 32'd3; validE = 1'b1;
         #1;
         vectors++;
         if (div_busy !== 1'b0) begin
            miscompares++; $display("FAIL mul_busy[%0d]: got %b expected 0", i, div_busy);
         end
         step();
         // Next instruction is an MFHI, which must not disturb HI/LO.
         alucontrolE = AluMfhi; srcaE = 32'h1234_5678; srcbE = 32'h9ABC_DEF0;
         #1;
         vectors++;
         if (hi_o !== exp_hi[i]) begin
            miscompares++; $display("FAIL mul_hi[%0d]: got %h expected %h", i, hi_o, exp_hi[i]);
         end
         vectors++;
         if (lo_o !== 32'hFFFF_FFFA) begin
            miscompares++; $display("FAIL mul_lo[%0d]: got %h expected %h", i, lo_o, 32'hFFFF_FFFA);
         end
         step();
         idle_inputs();
         #1;
         vectors++;
         if (hi_o !== exp_hi[i]) begin
            miscompares++; $display("FAIL mfhi_hold[%0d]: got %h expected %h", i, hi_o, exp_hi[i]);
         end
      end
   endtask

   task automatic test_no_start();
      alucontrolE = AluDiv; srcaE = 32'd9; srcbE = 32'd3; validE = 1'b0; cancelE = 1'b0;
      #1;
      vectors++;
      if (div_busy !== 1'b0) begin
         miscompares++; $display("FAIL nostart_invalid: got %b expected 0", div_busy);
      end
      validE = 1'b1; cancelE = 1'b1;
      #1;
      vectors++;
      if (div_busy !== 1'b0) begin
         miscompares++; $display("FAIL nostart_cancel: got %b expected 0", div_busy);
      end
      step();
      idle_inputs();
      #1;
      vectors++;
      if (div_busy !== 1'b0 || div_done !== 1'b0) begin
         miscompares++;
         $display("FAIL nostart_after: got busy=%b done=%b expected 0 0", div_busy, div_done);
      end
   endtask

   task automatic test_div();
      logic [4:0]  ctrl [6];
      logic [31:0] a [6];
      logic [31:0] b [6];
      logic [31:0] eh [6];
      logic [31:0] el [6];
      int          busy_n, last_busy, done_n, done_at;
      logic [31:0] hi_s, lo_s;
      ctrl[0] = AluDiv;  a[0] = 32'hFFFF_FFF9; b[0] = 32'd2;          eh[0] = 32'hFFFF_FFFF; el[0] = 32'hFFFF_FFFD;
      ctrl[1] = AluDivu; a[1] = 32'd7;         b[1] = 32'd2;          eh[1] = 32'd1;         el[1] = 32'd3;
      ctrl[2] = AluDiv;  a[2] = 32'h8000_0000; b[2] = 32'hFFFF_FFFF;  eh[2] = 32'd0;         el[2] = 32'h8000_0000;
      ctrl[3] = AluDivu; a[3] = 32'd5;         b[3] = 32'd0;          eh[3] = 32'd5;         el[3] = 32'hFFFF_FFFF;
      ctrl[4] = AluDiv;  a[4] = 32'hFFFF_FFF9; b[4] = 32'd0;          eh[4] = 32'hFFFF_FFF9; el[4] = 32'hFFFF_FFFF;
      ctrl[5] = AluDiv;  a[5] = 32'd7;         b[5] = 32'hFFFF_FFFE;  eh[5] = 32'd1;         el[5] = 32'hFFFF_FFFD;
      for (int i = 0; i < 6; i++) begin
         do_div(ctrl[i], a[i], b[i], busy_n, last_busy, done_n, done_at, hi_s, lo_s);
         vectors++;
         if (busy_n !== 33 || last_busy !== 32) begin
            miscompares++;
            $display("FAIL div_busy_len[%0d]: got %0d cycles last %0d expected 33 last 32",
                     i, busy_n, last_busy);
         end
         vectors++;
         if (done_n !== 1 || done_at !== 33) begin
            miscompares++;
            $display("FAIL div_done_pulse[%0d]: got %0d pulses at %0d expected 1 at 33",
                     i, done_n, done_at);
         end
         vectors++;
         if (hi_s !== eh[i]) begin
            miscompares++; $display("FAIL div_hi[%0d]: got %h expected %h", i, hi_s, eh[i]);
         end
         vectors++;
         if (lo_s !== el[i]) begin
            miscompares++; $display("FAIL div_lo[%0d]: got %h expected %h", i, lo_s, el[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int          busy_n, last_busy, done_n, done_at;
      logic [31:0] hi_s, lo_s;
      do_div(AluDivu, 32'd100, 32'd7, busy_n, last_busy, done_n, done_at, hi_s, lo_s);
      do_div(AluDivu, 32'd50, 32'd8, busy_n, last_busy, done_n, done_at, hi_s, lo_s);
      vectors++;
      if (busy_n !== 33 || done_n !== 1) begin
         miscompares++;
         $display("FAIL b2b_timing: got busy %0d done %0d expected 33 1", busy_n, done_n);
      end
      vectors++;
      if (hi_s !== 32'd2 || lo_s !== 32'd6) begin
         miscompares++; $display("FAIL b2b_result: got %h/%h expected 2/6", hi_s, lo_s);
      end
   endtask

   task automatic test_cancel();
      alucontrolE = AluMultu; srcaE = 32'h0001_0000; srcbE = 32'h0001_0000; validE = 1'b1;
      step();
      alucontrolE = AluDivu; srcaE = 32'd100; srcbE = 32'd7; validE = 1'b1;
      #1;
      vectors++;
      if (div_busy !== 1'b1) begin
         miscompares++; $display("FAIL cancel_accept_busy: got %b expected 1", div_busy);
      end
      vectors++;
      if (hi_o !== 32'd1 || lo_o !== 32'd0) begin
         miscompares++; $display("FAIL cancel_preload: got %h/%h expected 1/0", hi_o, lo_o);
      end
      for (int c = 1; c <= 10; c++) step();
      cancelE = 1'b1;
      #1;
      vectors++;
      if (div_busy !== 1'b0) begin
         miscompares++; $display("FAIL cancel_busy_drop: got %b expected 0", div_busy);
      end
      step();
      cancelE = 1'b0; alucontrolE = AluMultu; srcaE = 32'd2; srcbE = 32'd3; validE = 1'b1;
      #1;
      vectors++;
      if (hi_o !== 32'd1 || lo_o !== 32'd0 || div_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL cancel_no_write: got %h/%h busy %b expected 1/0 busy 0",
                  hi_o, lo_o, div_busy);
      end
      step();
      idle_inputs();
      #1;
      vectors++;
      if (hi_o !== 32'd0 || lo_o !== 32'd6) begin
         miscompares++; $display("FAIL cancel_then_mul: got %h/%h expected 0/6", hi_o, lo_o);
      end
   endtask

   task automatic test_reset_mid_div();
      int done_n, busy_n;
      alucontrolE = AluDiv; srcaE = 32'hFFFF_FFF9; srcbE = 32'd2; validE = 1'b1;
      for (int c = 0; c < 15; c++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle_inputs();
      #1;
      vectors++;
      if (div_busy !== 1'b0 || div_done !== 1'b0) begin
         miscompares++;
         $display("FAIL rstdiv_ctrl: got busy=%b done=%b expected 0 0", div_busy, div_done);
      end
      vectors++;
      if (hi_o !== 32'd0 || lo_o !== 32'd0) begin
         miscompares++; $display("FAIL rstdiv_hilo: got %h/%h expected 0/0", hi_o, lo_o);
      end
      done_n = 0; busy_n = 0;
      for (int c = 0; c < 40; c++) begin
         if (div_done) done_n++;
         if (div_busy) busy_n++;
         step();
      end
      vectors++;
      if (done_n !== 0 || busy_n !== 0 || lo_o !== 32'd0) begin
         miscompares++;
         $display("FAIL rstdiv_quiet: got done %0d busy %0d lo %h expected 0 0 0",
                  done_n, busy_n, lo_o);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_mul();
      test_no_start();
      test_div();
      test_back_to_back();
      test_cancel();
      test_reset_mid_div();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
